// File: rtl/xcvr_bus_ctrl_if.sv
// Host-side handshake and transceiver pins of the bus controller.
//
// Handshake rules (both channels): a transfer happens on the rising edge
// where valid and ready are both 1. Once valid is raised, the sender keeps
// it, and its payload, stable until that edge. Ready may rise and fall
// freely and never waits on valid.
// The request channel is i_req_valid/o_req_ready. The read response
// channel is o_rsp_valid/i_rsp_ready.
interface xcvr_bus_ctrl_if;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_we;
  logic [7:0] i_req_data;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_data;
  logic       o_wr_done;
  logic       o_dir;
  logic       o_oe;
  logic       o_a_drive;
  logic [7:0] o_a_out;
  logic [7:0] i_a_in;
  logic       o_busy;

  // Controller side.
  modport slave (
    input  i_req_valid, i_req_we, i_req_data, i_rsp_ready, i_a_in,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_wr_done,
    output o_dir, o_oe, o_a_drive, o_a_out, o_busy
  );

  // Host / environment side.
  modport master (
    output i_req_valid, i_req_we, i_req_data, i_rsp_ready, i_a_in,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_wr_done,
    input  o_dir, o_oe, o_a_drive, o_a_out, o_busy
  );
endinterface

// File: rtl/xcvr_bus_ctrl.sv
// Sequencer for a bidirectional bus transceiver (DIR/OE pair).
// Every transfer follows the same sequence:
//   1. SETUP: the transceiver is disabled and DIR is set.
//   2. ENABLE: the transceiver is enabled for TEN_CYC cycles.
//   3. DISABLE: the transceiver is disabled for TEN_CYC cycles.
// DIR therefore only moves while OE has been high for at least a cycle.
// Read data is captured on the last ENABLE edge and is then offered on a
// valid/ready response channel.
// TEN_CYC has a legal range of 1..15, which fits the 4-bit counter.
module xcvr_bus_ctrl #(
  parameter int unsigned TEN_CYC = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  xcvr_bus_ctrl_if.slave bus,
  output logic [2:0]     o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ENABLE  = 3'd2,
    S_DISABLE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  // The counter counts down to zero, so each phase lasts TEN_CYC cycles.
  localparam logic [3:0] CNT_LOAD = 4'(TEN_CYC - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_we;
  logic [3:0] r_cnt;
  logic       r_dir;
  logic       r_a_drive;
  logic [7:0] r_a_out;
  logic [7:0] r_rsp_data;

  logic w_req_ready;
  logic w_accept;
  logic w_cnt_last;
  logic w_oe;
  logic w_wr_done;
  logic w_rsp_valid;
  logic w_busy;

  assign w_accept   = w_req_ready & bus.i_req_valid;
  assign w_cnt_last = (r_cnt == 4'd0);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_oe        = 1'b1;
    w_wr_done   = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy      = 1'b0;
        // Ready is held low while reset is asserted.
        w_req_ready = i_rst_n;
        if (w_req_ready && bus.i_req_valid) w_next = S_SETUP;
      end
      S_SETUP: w_next = S_ENABLE;
      S_ENABLE: begin
        w_oe = 1'b0;
        if (w_cnt_last) w_next = S_DISABLE;
      end
      S_DISABLE: begin
        if (w_cnt_last) begin
          if (r_we) begin
            w_wr_done = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_next = S_RESP;
          end
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, phase counter, read capture and A-bus drive control.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we       <= 1'b0;
      r_cnt      <= 4'd0;
      r_dir      <= 1'b0;
      r_a_drive  <= 1'b0;
      r_a_out    <= 8'd0;
      r_rsp_data <= 8'd0;
    end else begin
      // DIR only changes here, on the edge that leaves IDLE, where OE is high.
      if (w_accept) begin
        r_we      <= bus.i_req_we;
        r_dir     <= bus.i_req_we;
        r_a_drive <= bus.i_req_we;
        r_a_out   <= bus.i_req_data;
      end
      case (r_state)
        S_SETUP:   r_cnt <= CNT_LOAD;
        S_ENABLE:  r_cnt <= w_cnt_last ? CNT_LOAD : r_cnt - 4'd1;
        S_DISABLE: r_cnt <= w_cnt_last ? 4'd0 : r_cnt - 4'd1;
        default:   r_cnt <= r_cnt;
      endcase
      if (r_state == S_ENABLE && w_cnt_last && !r_we) r_rsp_data <= bus.i_a_in;
      if (r_state == S_DISABLE && w_cnt_last) r_a_drive <= 1'b0;
    end
  end

  assign bus.o_req_ready = w_req_ready;
  assign bus.o_rsp_valid = w_rsp_valid;
  assign bus.o_rsp_data  = r_rsp_data;
  assign bus.o_wr_done   = w_wr_done;
  assign bus.o_dir       = r_dir;
  assign bus.o_oe        = w_oe;
  assign bus.o_a_drive   = r_a_drive;
  assign bus.o_a_out     = r_a_out;
  assign bus.o_busy      = w_busy;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_xcvr_bus_ctrl.sv
// Bench for xcvr_bus_ctrl.
// The main instance uses TEN_CYC=2 and runs directed transfers with a
// response scoreboard. The two extra instances use TEN_CYC=1 and 15 and
// check the phase lengths.
module tb_xcvr_bus_ctrl;
  localparam int TEN_MAIN = 2;

  logic clk;
  logic rst_n;
  logic [2:0] dbg_main;
  logic [2:0] dbg_aux [2];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int exp_acc  = 0;
  logic [8:0] exp_q[$];   // {is_write, expected data}
  bit aux_go   [2] = '{0, 0};
  bit aux_done [2] = '{0, 0};

  xcvr_bus_ctrl_if mif();
  xcvr_bus_ctrl #(.TEN_CYC(TEN_MAIN)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(mif.slave), .o_dbg_state(dbg_main)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic m_prev_dir, m_prev_oe, m_prev_rst;
  initial begin m_prev_dir = 1'b0; m_prev_oe = 1'b1; m_prev_rst = 1'b0; end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (mif.i_req_valid && mif.o_req_ready) n_acc++;
      if (mif.o_wr_done) begin
        if (exp_q.size() == 0) check("wr_done_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_done_kind", 1, {31'd0, e[8]});
          check("wr_done_a_out", mif.o_a_out, e[7:0]);
        end
      end
      if (mif.o_rsp_valid && mif.i_rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rsp_kind", 0, {31'd0, e[8]});
          check("rsp_data", mif.o_rsp_data, e[7:0]);
        end
      end
      if (mif.o_a_drive) check("a_drive_needs_dir", mif.o_dir, 1);
      if (m_prev_rst && (mif.o_dir != m_prev_dir)) check("dir_change_oe_prev", m_prev_oe, 1);
    end
    m_prev_dir = mif.o_dir;
    m_prev_oe  = mif.o_oe;
    m_prev_rst = rst_n;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int w = 0;
    while (!mif.o_req_ready && w < 50) begin @(posedge clk); #1; w++; end
    check("accept_wait", mif.o_req_ready, 1);
  endtask

  task automatic run_txn(input logic we, input logic [7:0] data, input logic [7:0] rd_val,
                         input int hold, input logic pend, input logic [7:0] pend_data);
    exp_q.push_back({we, we ? data : rd_val});
    exp_acc++;
    mif.i_req_valid = 1'b1;
    mif.i_req_we    = we;
    mif.i_req_data  = data;
    wait_ready();
    @(posedge clk); #1;
    // Request-side inputs change after acceptance and must have no effect.
    mif.i_req_valid = 1'b0;
    mif.i_req_we    = ~we;
    mif.i_req_data  = ~data;
    for (int c = 1; c <= 2 * TEN_MAIN + 1; c++) begin
      mif.i_a_in = (c == TEN_MAIN + 1) ? rd_val : ~rd_val;
      @(negedge clk);
      check("oe", mif.o_oe, (c >= 2 && c <= TEN_MAIN + 1) ? 1'b0 : 1'b1);
      check("dir", mif.o_dir, we);
      check("a_drive", mif.o_a_drive, we);
      check("a_out", mif.o_a_out, data);
      check("busy", mif.o_busy, 1);
      check("req_ready_busy", mif.o_req_ready, 0);
      check("wr_done_timing", mif.o_wr_done, (we && c == 2 * TEN_MAIN + 1) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    if (we) begin
      @(negedge clk);
      check("wr_end_a_drive", mif.o_a_drive, 0);
      check("wr_end_busy", mif.o_busy, 0);
      check("wr_end_ready", mif.o_req_ready, 1);
      check("wr_end_done", mif.o_wr_done, 0);
      check("wr_end_dir", mif.o_dir, 1);
      check("wr_end_oe", mif.o_oe, 1);
    end else begin
      for (int h = 0; h < hold; h++) begin
        if (pend) begin
          mif.i_req_valid = 1'b1;
          mif.i_req_we    = 1'b1;
          mif.i_req_data  = pend_data;
        end
        @(negedge clk);
        check("rsp_hold_valid", mif.o_rsp_valid, 1);
        check("rsp_hold_data", mif.o_rsp_data, rd_val);
        check("rsp_hold_ready", mif.o_req_ready, 0);
        check("rsp_hold_a_drive", mif.o_a_drive, 0);
        check("rsp_hold_oe", mif.o_oe, 1);
        @(posedge clk); #1;
      end
      mif.i_rsp_ready = 1'b1;
      @(negedge clk);
      check("rsp_valid_at_ready", mif.o_rsp_valid, 1);
      @(posedge clk); #1;
      mif.i_rsp_ready = 1'b0;
      @(negedge clk);
      check("rsp_cleared", mif.o_rsp_valid, 0);
      check("rsp_end_busy", mif.o_busy, 0);
      check("rsp_end_ready", mif.o_req_ready, 1);
      check("rsp_end_dir", mif.o_dir, 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_oe"}, mif.o_oe, 1);
    check({tag, "_dir"}, mif.o_dir, 0);
    check({tag, "_a_drive"}, mif.o_a_drive, 0);
    check({tag, "_a_out"}, mif.o_a_out, 0);
    check({tag, "_rsp_valid"}, mif.o_rsp_valid, 0);
    check({tag, "_rsp_data"}, mif.o_rsp_data, 0);
    check({tag, "_wr_done"}, mif.o_wr_done, 0);
    check({tag, "_busy"}, mif.o_busy, 0);
    check({tag, "_ready"}, mif.o_req_ready, 0);
  endtask

  // Abort a write during ENABLE with reset; no completion may appear.
  task automatic reset_mid_write();
    exp_acc++;
    mif.i_req_valid = 1'b1;
    mif.i_req_we    = 1'b1;
    mif.i_req_data  = 8'h77;
    wait_ready();
    @(posedge clk); #1;            // cycle 1, SETUP
    mif.i_req_valid = 1'b0;
    @(posedge clk); #1;            // cycle 2, ENABLE
    @(negedge clk);
    check("abort_pre_oe", mif.o_oe, 0);
    @(posedge clk); #1;            // cycle 3, still ENABLE
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_values("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_ready", mif.o_req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", mif.o_wr_done, 0);
      check("abort_no_rsp", mif.o_rsp_valid, 0);
    end
  endtask

  // ---------------- TEN_CYC=1 and TEN_CYC=15 instances ----------------
  for (genvar g = 0; g < 2; g++) begin : g_aux
    localparam int TC = (g == 0) ? 1 : 15;
    localparam logic [7:0] AIN = (g == 0) ? 8'h96 : 8'h69;
    xcvr_bus_ctrl_if aif();
    xcvr_bus_ctrl #(.TEN_CYC(TC)) u_aux (
      .i_clk(clk), .i_rst_n(rst_n), .bus(aif.slave), .o_dbg_state(dbg_aux[g])
    );

    logic p_dir, p_oe;
    initial begin p_dir = 1'b0; p_oe = 1'b1; end
    // DIR may only change when OE was already high in the previous cycle.
    always @(negedge clk) begin
      if (rst_n && m_prev_rst && (aif.o_dir != p_dir)) check("aux_dir_change_oe_prev", p_oe, 1);
      if (rst_n && aif.o_a_drive) check("aux_a_drive_needs_dir", aif.o_dir, 1);
      p_dir = aif.o_dir;
      p_oe  = aif.o_oe;
    end

    initial begin
      int en, dis, wd, w;
      aif.i_req_valid = 1'b0;
      aif.i_req_we    = 1'b0;
      aif.i_req_data  = 8'h00;
      aif.i_rsp_ready = 1'b1;    // also held high outside RESP
      aif.i_a_in      = AIN;
      wait (aux_go[g]);
      @(posedge clk); #1;
      for (int t = 0; t < 2; t++) begin
        aif.i_req_valid = 1'b1;
        aif.i_req_we    = (t == 0);
        aif.i_req_data  = 8'h5C;
        w = 0;
        while (!aif.o_req_ready && w < 50) begin @(posedge clk); #1; w++; end
        check("aux_accept_wait", aif.o_req_ready, 1);
        @(posedge clk); #1;
        aif.i_req_valid = 1'b0;
        @(negedge clk);
        check("aux_setup_oe", aif.o_oe, 1);
        check("aux_setup_dir", aif.o_dir, (t == 0) ? 1'b1 : 1'b0);
        en = 0; dis = 0; wd = 0;
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          if (!aif.o_busy || aif.o_rsp_valid) break;
          if (!aif.o_oe) en++;
          else begin
            dis++;
            if (aif.o_wr_done) wd = dis;
          end
        end
        check("aux_enable_len", en, TC);
        check("aux_disable_len", dis, TC);
        if (t == 0) begin
          check("aux_wr_done_last", wd, TC);
          check("aux_wr_end_a_drive", aif.o_a_drive, 0);
        end else begin
          check("aux_rsp_valid", aif.o_rsp_valid, 1);
          check("aux_rsp_data", aif.o_rsp_data, AIN);
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      check("aux_final_idle", aif.o_busy, 0);
      aux_done[g] = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    mif.i_req_valid = 1'b0;
    mif.i_req_we    = 1'b0;
    mif.i_req_data  = 8'h00;
    mif.i_rsp_ready = 1'b0;
    mif.i_a_in      = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", mif.o_req_ready, 1);

    run_txn(1'b1, 8'hA5, 8'h00, 0, 1'b0, 8'h00);   // plain write
    run_txn(1'b0, 8'h11, 8'h3C, 3, 1'b1, 8'h5A);   // immediate read, held response, queued write
    run_txn(1'b1, 8'h5A, 8'h00, 0, 1'b0, 8'h00);   // the queued write
    run_txn(1'b0, 8'h22, 8'h81, 0, 1'b0, 8'h00);   // read taken at once
    run_txn(1'b0, 8'h33, 8'hE4, 1, 1'b0, 8'h00);   // read after read, same direction
    reset_mid_write();
    run_txn(1'b1, 8'hE7, 8'h00, 0, 1'b0, 8'h00);   // normal write after abort
    run_txn(1'b0, 8'h44, 8'h42, 1, 1'b0, 8'h00);

    for (int g = 0; g < 2; g++) begin
      int t = 0;
      aux_go[g] = 1'b1;
      while (!aux_done[g] && t < 200) begin @(posedge clk); t++; end
      check("aux_done", aux_done[g], 1);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("accept_count", n_acc, exp_acc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time limit.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/xcvr_bus_ctrl.md
XCVR_BUS_CTRL -- requirements
Module: xcvr_bus_ctrl

Interface
REQ-001 Parameter TEN_CYC, default 2, meaning clock cycles of transceiver enable/disable time; legal range 1..15.
REQ-002 Clock and reset: one clock, i_clk; reset i_rst_n, synchronous, active-low, sampled on i_clk rising edge.
REQ-003 i_clk  in  1  system clock; all state changes on rising edge.
REQ-004 i_rst_n  in  1  synchronous active-low reset.
REQ-005 i_req_valid  in  1  host request valid.
REQ-006 o_req_ready  out  1  controller can accept a request.
REQ-007 i_req_we  in  1  1 = write (host A side to B side), 0 = read (B side to A side).
REQ-008 i_req_data  in  8  write data.
REQ-009 o_rsp_valid  out  1  read data valid.
REQ-010 i_rsp_ready  in  1  host accepts read data.
REQ-011 o_rsp_data  out  8  captured read data.
REQ-012 o_wr_done  out  1  one-cycle pulse on write completion.
REQ-013 o_dir  out  1  transceiver DIR; 1 = A to B, 0 = B to A.
REQ-014 o_oe  out  1  transceiver OE, active-high disable; 1 = both ports high-Z.
REQ-015 o_a_drive  out  1  host-side tristate enable for the A bus.
REQ-016 o_a_out  out  8  value driven on A when o_a_drive=1.
REQ-017 i_a_in  in  8  sampled A bus value.
REQ-018 o_busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, SETUP, ENABLE, DISABLE, RESP.
REQ-020 o_req_ready=1 only in IDLE with o_rsp_valid=0; request accepted on cycle where i_req_valid and o_req_ready are both 1.
REQ-021 On acceptance: latch i_req_we and i_req_data; next state SETUP.
REQ-022 SETUP, exactly 1 cycle: o_oe=1; o_dir=latched we; o_a_drive=latched we; o_a_out=latched data.
REQ-023 ENABLE, exactly TEN_CYC cycles: o_oe=0; o_dir, o_a_drive, o_a_out unchanged.
REQ-024 Read: o_rsp_data loaded from i_a_in on the last ENABLE cycle edge; no other capture.
REQ-025 DISABLE, exactly TEN_CYC cycles: o_oe=1; o_dir, o_a_drive held.
REQ-026 o_dir SHALL change only on an edge where o_oe was already 1 in the preceding cycle; o_oe=0 with a changing o_dir is illegal.
REQ-027 o_a_drive=1 only when o_dir=1; o_a_drive SHALL drop to 0 on the edge leaving DISABLE.
REQ-028 Write exit from DISABLE: o_wr_done=1 for that one cycle; next state IDLE.
REQ-029 Read exit from DISABLE: next state RESP; o_rsp_valid=1, held with o_rsp_data stable until i_rsp_ready=1.
REQ-030 RESP with i_rsp_ready=1: o_rsp_valid=0 next cycle, next state IDLE; i_rsp_ready ignored outside RESP.
REQ-031 Latency, TEN_CYC=N, accept at cycle 0: SETUP at 1, ENABLE 2..N+1, DISABLE N+2..2N+1, IDLE/RESP at 2N+2; write o_req_ready=1 again at cycle 2N+2.
REQ-032 In IDLE, o_oe=1; o_dir keeps its last value; o_a_drive=0.
REQ-033 Back-to-back: a request valid in the first IDLE cycle is accepted; SETUP is always inserted, even with unchanged direction.
REQ-034 Enable/disable counter is 4 bits, reloaded on entry to ENABLE and DISABLE; no wrap beyond TEN_CYC.
REQ-035 i_req_* changes after acceptance have no effect on the ongoing transfer.

Reset
REQ-036 With i_rst_n=0 at an edge: state IDLE, o_oe=1, o_dir=0, o_a_drive=0, o_a_out=0, o_rsp_valid=0, o_rsp_data=0, o_wr_done=0, o_busy=0, counter=0.
REQ-037 Reset mid-transfer: same values on the next edge; the aborted request produces no o_wr_done or o_rsp_valid.
REQ-038 o_req_ready=0 while i_rst_n=0; o_req_ready=1 on the first cycle after release.

Verification
REQ-039 Write 0xA5, TEN_CYC=2 -> o_dir=1 at cycle 1, o_oe=0 cycles 2-3, o_oe=1 cycles 4-5, o_wr_done at cycle 5, o_a_drive=0 at cycle 6.
REQ-040 Read, i_a_in=0x3C during ENABLE -> o_rsp_valid=1 at cycle 6, o_rsp_data=0x3C, held 3 cycles with i_rsp_ready=0, cleared the cycle after i_rsp_ready=1.
REQ-041 Write then immediate read -> o_dir 1->0 only while o_oe=1 for at least the prior cycle; o_a_drive never 1 with o_dir=0.
REQ-042 i_rst_n=0 asserted during ENABLE of a write -> next edge o_oe=1, o_a_drive=0, no o_wr_done; next request completes normally.
REQ-043 i_req_valid held high with pending read response -> o_req_ready=0 until response accepted; exactly one new acceptance afterwards.
REQ-044 TEN_CYC=1 and TEN_CYC=15 runs -> ENABLE and DISABLE each last exactly TEN_CYC cycles; assertion on REQ-026 never fires.
